// File: rtl/alu_issue.sv
// Issue/writeback front end for a combinational ALU.
// Decodes 16-bit instruction words, reads operands from a local register file
// (with forwarding from the retiring instruction), holds them in a one-entry
// issue register that drives the ALU, and writes the ALU result back.
module alu_issue #(
  parameter int unsigned DSIZE   = 16,
  parameter int unsigned NREG    = 16,
  parameter int unsigned MUL_LAT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_instr,
  output logic [2:0]       alu_op,
  output logic [DSIZE-1:0] alu_a,
  output logic [DSIZE-1:0] alu_b,
  input  logic [DSIZE-1:0] alu_result,
  input  logic             alu_zero,
  output logic             flag_zero,
  output logic             retire_valid,
  output logic [15:0]      retire_count,
  input  logic [3:0]       dbg_addr,
  output logic [DSIZE-1:0] dbg_data
);

  localparam logic [2:0] OpAdd   = 3'd0;
  localparam logic [2:0] OpMul   = 3'd7;
  localparam logic [2:0] CntLast = 3'(MUL_LAT - 1);

  // Issue register
  logic             iv_q, iv_d;
  logic [2:0]       op_q, op_d;
  logic [DSIZE-1:0] a_q, a_d;
  logic [DSIZE-1:0] b_q, b_d;
  logic [3:0]       rd_q, rd_d;
  logic [2:0]       cnt_q, cnt_d;

  // Architectural state
  logic [DSIZE-1:0] rf_q [NREG];
  logic [DSIZE-1:0] rf_d [NREG];
  logic             flag_zero_q, flag_zero_d;
  logic             retire_valid_q, retire_valid_d;
  logic [15:0]      retire_count_q, retire_count_d;

  // Decode fields
  logic [3:0]       opc, rd_f, rs1_f, rs2_f;
  logic [DSIZE-1:0] rs1_val, rs2_val, dbg_val;
  logic [DSIZE-1:0] a_new, b_new;

  logic mul_hold, retire, accept, fwd_en;

  assign opc   = in_instr[15:12];
  assign rd_f  = in_instr[11:8];
  assign rs1_f = in_instr[7:4];
  assign rs2_f = in_instr[3:0];

  // Handshake and retire conditions; a MUL blocks the issue slot until its last held cycle
  always_comb begin
    mul_hold = iv_q && (op_q == OpMul) && (cnt_q != CntLast);
    retire   = iv_q && !mul_hold;
    in_ready = !mul_hold;
    accept   = in_valid && in_ready;
    fwd_en   = retire && (rd_q != 4'd0);
  end

  // Register-file reads; r0 and out-of-range addresses read as zero
  always_comb begin
    rs1_val = '0;
    rs2_val = '0;
    dbg_val = '0;
    for (int i = 1; i < NREG; i++) begin
      if (rs1_f == 4'(i))    rs1_val = rf_q[i];
      if (rs2_f == 4'(i))    rs2_val = rf_q[i];
      if (dbg_addr == 4'(i)) dbg_val = rf_q[i];
    end
  end

  // Operand selection with forwarding from the instruction retiring on this edge
  always_comb begin
    a_new = (fwd_en && (rs1_f == rd_q)) ? alu_result : rs1_val;
    if (opc[3]) begin
      b_new = {{(DSIZE - 4){1'b0}}, rs2_f};
    end else begin
      b_new = (fwd_en && (rs2_f == rd_q)) ? alu_result : rs2_val;
    end
  end

  // Next-state for the issue register, write-back and retire bookkeeping
  always_comb begin
    iv_d           = iv_q;
    op_d           = op_q;
    a_d            = a_q;
    b_d            = b_q;
    rd_d           = rd_q;
    cnt_d          = cnt_q;
    rf_d           = rf_q;
    flag_zero_d    = flag_zero_q;
    retire_valid_d = retire;
    retire_count_d = retire_count_q;

    if (mul_hold) begin
      cnt_d = cnt_q + 3'd1;
    end

    if (retire) begin
      iv_d           = 1'b0;
      flag_zero_d    = alu_zero;
      retire_count_d = retire_count_q + 16'd1;
      for (int i = 1; i < NREG; i++) begin
        if (rd_q == 4'(i)) rf_d[i] = alu_result;
      end
    end

    if (accept) begin
      iv_d  = 1'b1;
      op_d  = opc[2:0];
      a_d   = a_new;
      b_d   = b_new;
      rd_d  = rd_f;
      cnt_d = 3'd0;
    end
  end

  // State registers with synchronous reset; a partially held MUL is dropped
  always_ff @(posedge clk) begin
    if (rst) begin
      iv_q           <= 1'b0;
      op_q           <= OpAdd;
      a_q            <= '0;
      b_q            <= '0;
      rd_q           <= 4'd0;
      cnt_q          <= 3'd0;
      flag_zero_q    <= 1'b0;
      retire_valid_q <= 1'b0;
      retire_count_q <= 16'd0;
      for (int i = 0; i < NREG; i++) begin
        rf_q[i] <= '0;
      end
    end else begin
      iv_q           <= iv_d;
      op_q           <= op_d;
      a_q            <= a_d;
      b_q            <= b_d;
      rd_q           <= rd_d;
      cnt_q          <= cnt_d;
      flag_zero_q    <= flag_zero_d;
      retire_valid_q <= retire_valid_d;
      retire_count_q <= retire_count_d;
      for (int i = 0; i < NREG; i++) begin
        rf_q[i] <= rf_d[i];
      end
    end
  end

  // ALU drive: idle issue slot presents ADD 0,0
  always_comb begin
    alu_op       = iv_q ? op_q : OpAdd;
    alu_a        = iv_q ? a_q : '0;
    alu_b        = iv_q ? b_q : '0;
    flag_zero    = flag_zero_q;
    retire_valid = retire_valid_q;
    retire_count = retire_count_q;
    dbg_data     = dbg_val;
  end

endmodule

// File: tb/tb_alu_issue.sv
// Randomised scoreboard bench for alu_issue. The bench supplies the ALU itself and
// keeps an architectural register-file model in which each instruction sees the
// results of every older one.
module tb_alu_issue;

  localparam int MulLat = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_instr;
  logic [2:0]  alu_op;
  logic [15:0] alu_a, alu_b, alu_result;
  logic        alu_zero;
  logic        flag_zero;
  logic        retire_valid;
  logic [15:0] retire_count;
  logic [3:0]  dbg_addr;
  logic [15:0] dbg_data;

  alu_issue #(.DSIZE(16), .NREG(16), .MUL_LAT(MulLat)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_instr     (in_instr),
    .alu_op       (alu_op),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_result   (alu_result),
    .alu_zero     (alu_zero),
    .flag_zero    (flag_zero),
    .retire_valid (retire_valid),
    .retire_count (retire_count),
    .dbg_addr     (dbg_addr),
    .dbg_data     (dbg_data)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] alu_fn(input logic [2:0] op, input logic [15:0] a,
                                         input logic [15:0] b);
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a ^ b;
      3'd4: return a << b;
      3'd5: return a >> b;
      3'd6: return (a < b) ? 16'd1 : 16'd0;
      default: return 16'(32'(a) * 32'(b));
    endcase
  endfunction

  // The ALU environment
  always_comb begin
    alu_result = alu_fn(alu_op, alu_a, alu_b);
    alu_zero   = (alu_a == alu_b);
  end

  typedef struct {
    logic [2:0]  op;
    logic [15:0] a;
    logic [15:0] b;
  } issue_t;

  typedef struct {
    logic [15:0] res;
    logic        zero;
  } ret_t;

  issue_t      issue_q[$];
  ret_t        ret_q[$];
  logic [15:0] model_rf [16];
  logic [15:0] exp_cnt;
  int          pulses;
  int          checks = 0;
  int          errors = 0;
  logic        acc_last = 1'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 16; i++) model_rf[i] = 16'd0;
    issue_q.delete();
    ret_q.delete();
    exp_cnt = 16'd0;
  endtask

  // Monitor: checks each issue on the cycle after it is accepted, and each retire pulse
  initial begin
    issue_t ei;
    ret_t   er;
    forever begin
      @(negedge clk);
      if (acc_last) begin
        if (issue_q.size() == 0) begin
          chk("issue_unexpected", 32'd1, 32'd0);
        end else begin
          ei = issue_q.pop_front();
          chk("issue_op", 32'(alu_op), 32'(ei.op));
          chk("issue_a", 32'(alu_a), 32'(ei.a));
          chk("issue_b", 32'(alu_b), 32'(ei.b));
        end
      end
      acc_last = in_valid && in_ready && !rst;
      if (retire_valid === 1'b1) begin
        pulses++;
        if (ret_q.size() == 0) begin
          chk("retire_unexpected", 32'd1, 32'd0);
        end else begin
          er = ret_q.pop_front();
          exp_cnt = exp_cnt + 16'd1;
          chk("flag_zero", 32'(flag_zero), 32'(er.zero));
          chk("retire_count", 32'(retire_count), 32'(exp_cnt));
        end
      end
    end
  end

  // Present one instruction, record its architectural effect, wait for acceptance
  task automatic send(input logic [15:0] instr, output int waits);
    logic [3:0]  opc, rd, rs1, rs2;
    logic [15:0] a, b, res;
    issue_t      ei;
    ret_t        er;
    {opc, rd, rs1, rs2} = instr;
    a   = model_rf[rs1];
    b   = opc[3] ? {12'd0, rs2} : model_rf[rs2];
    res = alu_fn(opc[2:0], a, b);
    if (rd != 4'd0) model_rf[rd] = res;
    ei.op = opc[2:0]; ei.a = a; ei.b = b;
    er.res = res; er.zero = (a == b);
    issue_q.push_back(ei);
    ret_q.push_back(er);
    in_valid = 1'b1;
    in_instr = instr;
    waits = 0;
    while (!in_ready && waits < 20) begin
      @(posedge clk); #1;
      waits++;
    end
    if (!in_ready) begin
      chk("accept_timeout", 32'd1, 32'd0);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((ret_q.size() != 0 || issue_q.size() != 0) && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending", 32'(ret_q.size() + issue_q.size()), 32'd0);
    @(negedge clk);
  endtask

  task automatic sweep();
    for (int r = 0; r < 16; r++) begin
      dbg_addr = 4'(r);
      #1;
      chk($sformatf("dbg_r%0d", r), 32'(dbg_data), 32'(model_rf[r]));
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_clear();
  endtask

  initial begin
    int w, w2, p0;
    logic [15:0] instr;
    rst = 1'b1; in_valid = 1'b0; in_instr = 16'd0; dbg_addr = 4'd0; pulses = 0;
    model_clear();
    do_reset();

    // Reset state
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_retire_count", 32'(retire_count), 32'd0);
    chk("rst_retire_valid", 32'(retire_valid), 32'd0);
    chk("rst_flag_zero", 32'(flag_zero), 32'd0);
    chk("rst_alu_op", 32'(alu_op), 32'd0);
    chk("rst_alu_a", 32'(alu_a), 32'd0);
    chk("rst_alu_b", 32'(alu_b), 32'd0);

    // Reset during cycle 1 of a MUL: dropped, never retired
    send({4'h7, 4'd3, 4'd0, 4'd0}, w);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    model_clear();
    chk("mulrst_in_ready", 32'(in_ready), 32'd1);
    chk("mulrst_retire_count", 32'(retire_count), 32'd0);
    repeat (4) @(negedge clk);
    sweep();

    // ADDI r1 = 0 + 5
    @(posedge clk); #1;
    send({4'h8, 4'd1, 4'd0, 4'd5}, w);
    drain();
    chk("addi_retire_count", 32'(retire_count), 32'd1);
    sweep();

    // Back-to-back dependent ops
    @(posedge clk); #1;
    send({4'h8, 4'd1, 4'd0, 4'd3}, w);
    send({4'h0, 4'd2, 4'd1, 4'd1}, w);
    chk("b2b_waits", 32'(w), 32'd0);
    drain();
    sweep();

    // MUL stall
    @(posedge clk); #1;
    p0 = pulses;
    send({4'h8, 4'd1, 4'd0, 4'd7}, w);
    send({4'h8, 4'd2, 4'd0, 4'd6}, w);
    send({4'h7, 4'd3, 4'd1, 4'd2}, w);
    send({4'h8, 4'd7, 4'd0, 4'd1}, w2);
    chk("mul_stall_cycles", 32'(w2), 32'(MulLat - 1));
    drain();
    chk("mul_pulses", 32'(pulses - p0), 32'd4);
    chk("mul_r3", 32'(model_rf[3]), 32'd42);
    sweep();

    // Zero flag
    @(posedge clk); #1;
    send({4'h1, 4'd4, 4'd1, 4'd1}, w);
    drain();
    chk("sub_flag_zero", 32'(flag_zero), 32'd1);
    @(posedge clk); #1;
    send({4'h3, 4'd5, 4'd1, 4'd2}, w);
    drain();
    chk("xor_flag_zero", 32'(flag_zero), 32'd0);
    sweep();

    // r0 protection, no forwarding from rd=0
    @(posedge clk); #1;
    send({4'h8, 4'd0, 4'd0, 4'd9}, w);
    send({4'h0, 4'd6, 4'd0, 4'd1}, w);
    drain();
    sweep();

    // Random traffic
    @(posedge clk); #1;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(3) == 0) begin
        @(posedge clk); #1;
      end
      instr = 16'($urandom);
      send(instr, w);
      if (i % 250 == 249) begin
        drain();
        sweep();
        @(posedge clk); #1;
      end
    end
    drain();
    sweep();

    // Counter wrap
    do_reset();
    pulses = 0;
    for (int i = 0; i < 65536; i++) begin
      instr = {4'h8, 4'($urandom), 4'($urandom), 4'($urandom)};
      send(instr, w);
    end
    drain();
    chk("wrap_retire_count", 32'(retire_count), 32'd0);
    chk("wrap_pulses", 32'(pulses), 32'd65536);
    sweep();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
